// File: rtl/data_mem_responder_pkg.sv
// Shared constants and state encoding for the data memory responder.
package data_mem_responder_pkg;

    localparam int DMR_ADDR_W = 12;    // matches the core's main-memory address width
    localparam int DMR_DATA_W = 16;    // memory word width
    localparam int DMR_DEPTH  = 4096;  // implemented words, at most 2**DMR_ADDR_W

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        LD_RSP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core main-memory port plus host loader port, bundled for the responder.
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DMR_ADDR_W,
    parameter int DATA_W = DMR_DATA_W
);

    // Core side
    logic              cpu_active;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_rw;
    logic [DATA_W-1:0] cpu_q;

    // Loader side
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    // Requesters (core and host) drive addresses and data.
    modport master (
        output cpu_active, cpu_addr, cpu_data, cpu_rw,
        output ld_valid, ld_we, ld_addr, ld_wdata,
        input  cpu_q, ld_ready, rsp_valid, rsp_rdata
    );

    // The memory responder answers both requesters.
    modport slave (
        input  cpu_active, cpu_addr, cpu_data, cpu_rw,
        input  ld_valid, ld_we, ld_addr, ld_wdata,
        output cpu_q, ld_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous RAM, one-cycle read latency, write-first on write.
module data_mem_responder_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = DMR_DATA_W,
    parameter int DEPTH  = DMR_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write the addressed word, and return either the new word or the stored one.
    // NOTE: no reset here -- resetting a RAM array would force it into flops; contents
    // are defined only by writes (the zero-fill sequencer exists for that).
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q   <= mem[addr];
        end
    end

    assign q = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: core port, host loader port and zero-fill sequencer
// sharing one single-port RAM. Port priority is CLEAR > core > loader.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DMR_ADDR_W,
    parameter int DATA_W = DMR_DATA_W,
    parameter int DEPTH  = DMR_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    input  logic                 init_start,
    output logic                 clr_busy,
    output logic                 cpu_conflict
);

    localparam int              AW     = $clog2(DEPTH);
    // Counter and range compare are one bit wider than the address so that
    // DEPTH == 2**ADDR_W is representable and the clear terminates without wrap.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              conflict_q, conflict_d;
    // cpu_q / rsp_rdata come straight from the RAM output for the cycle after a
    // real read, otherwise from a holding register (held value, zero, or echo).
    logic              cpu_sel_q, cpu_sel_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic              rsp_sel_q, rsp_sel_d;
    logic [DATA_W-1:0] rsp_hold_q, rsp_hold_d;

    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q;

    logic              cpu_in_range;
    logic              ld_in_range;
    logic              ld_accept;

    assign cpu_in_range = {1'b0, bus.cpu_addr} < DEPTH_C;
    assign ld_in_range  = {1'b0, bus.ld_addr}  < DEPTH_C;

    // Loader is only admitted when idle, the core is off the bus and no clear is requested.
    assign bus.ld_ready = (state_q == IDLE) & ~bus.cpu_active & ~init_start & ~reset;
    assign ld_accept    = bus.ld_valid & bus.ld_ready;

    assign bus.rsp_valid = (state_q == LD_RSP);
    assign bus.rsp_rdata = rsp_sel_q ? mem_q : rsp_hold_q;
    assign bus.cpu_q     = cpu_sel_q ? mem_q : cpu_hold_q;
    assign clr_busy      = (state_q == CLEAR);
    assign cpu_conflict  = conflict_q;

    data_mem_responder_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .q     (mem_q)
    );

    // Next state and clear counter.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a signal
        // unassigned and no latch is inferred.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (ld_accept) begin
                    state_d   = LD_RSP;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                if (clr_cnt_q == LAST_C) begin
                    state_d = IDLE;
                end
            end
            LD_RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port mux: clear sequencer, then core, then loader; out-of-range accesses never reach the RAM.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q[AW-1:0];
        end else if (bus.cpu_active) begin
            if (cpu_in_range) begin
                mem_we    = bus.cpu_rw;
                mem_addr  = bus.cpu_addr[AW-1:0];
                mem_wdata = bus.cpu_data;
            end
        end else if (ld_accept && ld_in_range) begin
            mem_we    = bus.ld_we;
            mem_addr  = bus.ld_addr[AW-1:0];
            mem_wdata = bus.ld_wdata;
        end
    end

    // Read-data source selection for both ports and the sticky conflict flag.
    always_comb begin
        cpu_sel_d  = 1'b0;
        cpu_hold_d = bus.cpu_q;
        rsp_sel_d  = 1'b0;
        rsp_hold_d = bus.rsp_rdata;
        conflict_d = conflict_q;
        if (bus.cpu_active) begin
            if (state_q == CLEAR) begin
                conflict_d = 1'b1;
                cpu_hold_d = '0;
            end else if (cpu_in_range) begin
                cpu_sel_d  = 1'b1;
            end else begin
                cpu_hold_d = '0;
            end
        end
        if (ld_accept) begin
            if (bus.ld_we) begin
                rsp_hold_d = bus.ld_wdata;
            end else if (ld_in_range) begin
                rsp_sel_d  = 1'b1;
            end else begin
                rsp_hold_d = '0;
            end
        end
    end

    // State registers with asynchronous reset; an in-flight clear is simply abandoned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            conflict_q <= 1'b0;
            cpu_sel_q  <= 1'b0;
            cpu_hold_q <= '0;
            rsp_sel_q  <= 1'b0;
            rsp_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            conflict_q <= conflict_d;
            cpu_sel_q  <= cpu_sel_d;
            cpu_hold_q <= cpu_hold_d;
            rsp_sel_q  <= rsp_sel_d;
            rsp_hold_q <= rsp_hold_d;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=16 so out-of-range is easy to reach).
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    typedef struct {
        logic              act;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_q;
    } core_vec_t;

    logic clock = 1'b0;
    logic reset;
    logic init_start;
    logic clr_busy;
    logic cpu_conflict;

    data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .init_start   (init_start),
        .clr_busy     (clr_busy),
        .cpu_conflict (cpu_conflict)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q;
    core_vec_t         vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_active = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_data   = '0;
        bus.cpu_rw     = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_wdata   = '0;
        init_start     = 1'b0;
    endtask

    task automatic core_rd(input logic [ADDR_W-1:0] a);
        bus.cpu_active = 1'b1;
        bus.cpu_rw     = 1'b0;
        bus.cpu_addr   = a;
        tick();
    endtask

    // Count sampled cycles with clr_busy high, starting with the current sample.
    task automatic count_busy(output int n);
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 99) < 80) return 12'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 1) == 1) return 12'($urandom_range(DEPTH, 2 * DEPTH - 1));
        return 12'hFFF;
    endfunction

    initial begin
        int                n;
        logic              pending;
        logic              accept;
        logic              r_act, r_rw, r_lv, r_we;
        logic [ADDR_W-1:0] r_addr, r_la;
        logic [DATA_W-1:0] r_data, r_wd, exp_rd;

        // Core-port vectors, applied after the array has been zero-filled.
        vecs[0]  = '{1'b1, 1'b1, 12'h00A, 16'h1234, 16'h1234}; // write-first
        vecs[1]  = '{1'b1, 1'b0, 12'h00A, 16'h0000, 16'h1234}; // read back
        vecs[2]  = '{1'b0, 1'b1, 12'h00A, 16'hFFFF, 16'h1234}; // inactive: hold, no write
        vecs[3]  = '{1'b1, 1'b0, 12'h00A, 16'h0000, 16'h1234}; // write really ignored
        vecs[4]  = '{1'b1, 1'b1, 12'h010, 16'hAAAA, 16'h0000}; // out of range write
        vecs[5]  = '{1'b1, 1'b0, 12'h000, 16'h0000, 16'h0000}; // no alias onto word 0
        vecs[6]  = '{1'b1, 1'b1, 12'h00F, 16'h5A5A, 16'h5A5A}; // last word
        vecs[7]  = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'h0000}; // first out-of-range read
        vecs[8]  = '{1'b0, 1'b0, 12'h00F, 16'h0000, 16'h0000}; // hold zero
        vecs[9]  = '{1'b1, 1'b0, 12'h00F, 16'h0000, 16'h5A5A};
        vecs[10] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'h0000};

        // ---- reset values
        idle_inputs();
        reset = 1'b1;
        #12;
        check("rst_cpu_q",     32'(bus.cpu_q), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        check("rst_clr_busy",  32'(clr_busy), 32'h0);
        check("rst_conflict",  32'(cpu_conflict), 32'h0);
        check("rst_ld_ready",  32'(bus.ld_ready), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // ---- zero-fill, with a loader request colliding on the start cycle
        init_start   = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 12'h001;
        bus.ld_wdata = 16'h9999;
        #1;
        check("clr_start_ld_ready", 32'(bus.ld_ready), 32'h0);
        tick();
        idle_inputs();
        check("clr_start_no_rsp", 32'(bus.rsp_valid), 32'h0);
        count_busy(n);
        check("clr_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            core_rd(12'(i));
            check("clr_read_zero", 32'(bus.cpu_q), 32'h0);
        end

        // ---- core port table
        for (int i = 0; i < 11; i++) begin
            bus.cpu_active = vecs[i].act;
            bus.cpu_rw     = vecs[i].rw;
            bus.cpu_addr   = vecs[i].addr;
            bus.cpu_data   = vecs[i].data;
            tick();
            check($sformatf("core_vec%0d", i), 32'(bus.cpu_q), 32'(vecs[i].exp_q));
            if (vecs[i].act && vecs[i].rw && in_range(vecs[i].addr))
                model_mem[int'(vecs[i].addr)] = vecs[i].data;
        end
        idle_inputs();

        // ---- loader write then read, back to back
        bus.ld_valid = 1'b1;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 12'h00F;
        bus.ld_wdata = 16'hBEEF;
        #1;
        check("ld_ready_idle", 32'(bus.ld_ready), 32'h1);
        tick();
        model_mem[15] = 16'hBEEF;
        check("ld_wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("ld_wr_rsp_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
        check("ld_wr_ready_low", 32'(bus.ld_ready), 32'h0);
        bus.ld_we = 1'b0;
        tick();
        check("ld_gap_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("ld_gap_ready",     32'(bus.ld_ready), 32'h1);
        tick();
        check("ld_rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("ld_rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
        check("ld_rd_ready_low", 32'(bus.ld_ready), 32'h0);
        bus.ld_valid = 1'b0;
        tick();
        check("ld_single_pulse", 32'(bus.rsp_valid), 32'h0);

        // ---- loader out-of-range: write acknowledged and echoed, read returns 0
        bus.ld_valid = 1'b1;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 12'h0FF;
        bus.ld_wdata = 16'h1111;
        tick();
        check("ld_oor_wr_valid", 32'(bus.rsp_valid), 32'h1);
        check("ld_oor_wr_echo",  32'(bus.rsp_rdata), 32'h1111);
        bus.ld_we = 1'b0;
        tick();
        tick();
        check("ld_oor_rd_valid", 32'(bus.rsp_valid), 32'h1);
        check("ld_oor_rd_zero",  32'(bus.rsp_rdata), 32'h0);
        bus.ld_addr = 12'h00F;
        tick();
        tick();
        check("ld_no_alias", 32'(bus.rsp_rdata), 32'hBEEF);
        bus.ld_valid = 1'b0;
        tick();
        check("cpu_q_held_over_loader", 32'(bus.cpu_q), 32'(exp_q));

        // ---- loader blocked while the core owns memory
        bus.cpu_active = 1'b1;
        bus.cpu_rw     = 1'b0;
        bus.cpu_addr   = 12'h000;
        bus.ld_valid   = 1'b1;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = 12'h00A;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("blk_ld_ready", 32'(bus.ld_ready), 32'h0);
            tick();
            check("blk_no_rsp", 32'(bus.rsp_valid), 32'h0);
            check("blk_cpu_q",  32'(bus.cpu_q), 32'(model_mem[0]));
        end
        bus.cpu_active = 1'b0;
        #1;
        check("unblk_ld_ready", 32'(bus.ld_ready), 32'h1);
        tick();
        bus.ld_valid = 1'b0;
        // Core takes the bus during the response cycle; the response must survive.
        bus.cpu_active = 1'b1;
        bus.cpu_rw     = 1'b1;
        bus.cpu_addr   = 12'h002;
        bus.cpu_data   = 16'h2222;
        #1;
        check("unblk_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("unblk_rsp_rdata", 32'(bus.rsp_rdata), 32'(model_mem[10]));
        tick();
        model_mem[2] = 16'h2222;
        check("core_in_ld_rsp", 32'(bus.cpu_q), 32'h2222);
        check("ld_rsp_done",    32'(bus.rsp_valid), 32'h0);
        idle_inputs();

        // ---- core access during clear
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        tick();
        bus.cpu_active = 1'b1;
        bus.cpu_rw     = 1'b1;
        bus.cpu_addr   = 12'h003;
        bus.cpu_data   = 16'h7777;
        tick();
        idle_inputs();
        check("conf_cpu_q",   32'(bus.cpu_q), 32'h0);
        check("conf_flag",    32'(cpu_conflict), 32'h1);
        check("conf_busy",    32'(clr_busy), 32'h1);
        count_busy(n);
        check("conf_busy_cycles", 32'(n + 3), 32'd16);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        core_rd(12'h003);
        check("conf_word3_zero", 32'(bus.cpu_q), 32'h0);
        check("conf_sticky",     32'(cpu_conflict), 32'h1);
        exp_q = '0;

        // ---- randomized traffic against the transaction-level model
        idle_inputs();
        tick();
        pending = 1'b0;
        for (int it = 0; it < 400; it++) begin
            r_act  = ($urandom_range(0, 99) < 45);
            r_rw   = 1'($urandom_range(0, 1));
            r_addr = rand_addr();
            r_data = 16'($urandom);
            r_lv   = ($urandom_range(0, 99) < 60);
            r_we   = 1'($urandom_range(0, 1));
            r_la   = rand_addr();
            r_wd   = 16'($urandom);
            bus.cpu_active = r_act;
            bus.cpu_rw     = r_rw;
            bus.cpu_addr   = r_addr;
            bus.cpu_data   = r_data;
            bus.ld_valid   = r_lv;
            bus.ld_we      = r_we;
            bus.ld_addr    = r_la;
            bus.ld_wdata   = r_wd;
            #1;
            check("rnd_ld_ready", 32'(bus.ld_ready), 32'(!pending && !r_act));
            accept = r_lv && !pending && !r_act;
            if (r_act) begin
                if (in_range(r_addr)) begin
                    if (r_rw) model_mem[int'(r_addr)] = r_data;
                    exp_q = model_mem[int'(r_addr)];
                end else begin
                    exp_q = '0;
                end
            end
            exp_rd = '0;
            if (accept) begin
                if (r_we) begin
                    exp_rd = r_wd;
                    if (in_range(r_la)) model_mem[int'(r_la)] = r_wd;
                end else if (in_range(r_la)) begin
                    exp_rd = model_mem[int'(r_la)];
                end
            end
            tick();
            check("rnd_cpu_q",     32'(bus.cpu_q), 32'(exp_q));
            check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(accept));
            if (accept) check("rnd_rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
            pending = accept;
        end
        idle_inputs();
        tick();
        tick();

        // ---- reset in the middle of a clear
        for (int i = 0; i < DEPTH; i++) begin
            bus.cpu_active = 1'b1;
            bus.cpu_rw     = 1'b1;
            bus.cpu_addr   = 12'(i);
            bus.cpu_data   = 16'(16'h1000 + i);
            tick();
        end
        idle_inputs();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (5) tick();
        check("mid_clr_busy", 32'(clr_busy), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_clr_busy", 32'(clr_busy), 32'h0);
        check("abort_conflict", 32'(cpu_conflict), 32'h0);
        #2;
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i != 5) begin
                core_rd(12'(i));
                check($sformatf("abort_word%0d", i), 32'(bus.cpu_q),
                      (i < 5) ? 32'h0 : 32'h1006);
            end
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
